bus_cpu_seq: RTL and testbench
==============================

// Module: bus_cpu_seq
// PURPOSE
//   Parametrised multicycle bus processor: the successor to the fixed 4-register datapath behind `integration`.
//   - One shared internal bus; every cycle at most one source drives it, selected by one-hot tri_en.
//   - Register file and ALU width are parameters. Adds ALU ops, a zero flag, a BZ/JMP branch unit, a PC,
//     and a valid/ready instruction fetch handshake.
// PARAMETERS
//   W     8  data width of bus, registers, A, G and imm
//   NREG  4  register count; power of two, >=2; RIDX=$clog2(NREG) (localparam)
//   PC_W  8  program counter width
//   IW = 3+2*RIDX+W (localparam); instr = {op[2:0], rx[RIDX-1:0], ry[RIDX-1:0], imm[W-1:0]}
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous reset, active-high
//   instr_valid  in   1       instr holds a valid instruction
//   instr_ready  out  1       sequencer can accept; high only in FETCH
//   instr        in   IW      instruction word
//   pc           out  PC_W    address of the instruction being fetched/executed
//   bus          out  W       shared bus value; 0 when undriven
//   tri_en       out  NREG+2  one-hot source: [NREG-1:0]=Rn, [NREG]=imm, [NREG+1]=G; all 0 when idle
//   done         out  1       one-cycle pulse in the last execute cycle of each instruction
//   zero         out  1       zero flag (ALU result == 0)
//   dbg_sel      in   RIDX    debug register select
//   dbg_data     out  W       Rn[dbg_sel], combinational
// BEHAVIOUR
//   Reset (async, rst=1):
//     - pc, all Rn, A, G, zero=0; state=FETCH; done=0.
//     - instr_ready=0 while rst=1.
//     - Aborts any instruction in flight with no register write.
//   Register conventions:
//     - IR latched on handshake.
//     - All writes occur at the clock edge ending the named state.
//     - Arithmetic wraps mod 2^W.
//   FETCH:
//     - instr_ready=1, tri_en=0, bus=0.
//     - On instr_valid&&instr_ready, IR<=instr and go to T1; otherwise hold indefinitely.
//   Execute, by op:
//     000 LOAD  T1: drive imm, Rx<=bus, done, pc<=pc+1 -> FETCH
//     001 MV    T1: drive Ry, Rx<=bus, done, pc+1 -> FETCH (rx==ry is a legal no-op write)
//     010 ADD, 011 SUB, 100 AND, 101 XOR (three cycles):
//         T1: drive Rx, A<=bus
//         T2: drive Ry, G<=A op bus (SUB = A-bus)
//         T3: drive G, Rx<=G, zero<=(G==0), done, pc+1 -> FETCH
//         rx==ry is legal: ADD doubles Rx, SUB/XOR clear it.
//     110 BZ    T1: no bus drive; pc<= zero ? pc+sext(imm[PC_W-1:0]) : pc+1; done -> FETCH
//     111 JMP   T1: no bus drive; pc<=imm[PC_W-1:0]; done -> FETCH
//   Latency from accept edge to done: 1 cycle for LOAD/MV/BZ/JMP, 3 cycles for ALU ops.
//   Throughput: next accept at the earliest in the cycle after done.
//   Flags: only ALU ops update zero; LOAD/MV/BZ/JMP preserve it.
//   PC arithmetic wraps mod 2^PC_W. If PC_W>W, imm is zero-padded for JMP and sign-extended for BZ.
//   tri_en is strictly one-hot or zero every cycle, never two drivers; bus equals the selected source.
// TESTING
//   1. LOAD R0,5; LOAD R1,3; ADD R0,R1
//      -> R0=8, zero=0, pc=3; ADD done exactly 3 cycles after accept.
//   2. R0=3,R1=5, SUB R0,R1 -> R0=0xFE, zero=0. Then LOAD R2,7; SUB R2,R2 -> R2=0, zero=1.
//   3. Branches:
//      - zero=1, pc=5, BZ imm=0xFE -> pc=3.
//      - zero=0, BZ -> pc=6.
//      - JMP imm=0x40 -> pc=0x40.
//      - pc=0xFF, LOAD -> pc wraps to 0.
//   4. Stall and flag preservation:
//      - instr_valid=0 for 5 cycles -> pc, regs, tri_en=0, bus=0 unchanged, instr_ready=1.
//      - LOAD/MV after zero=1 -> zero stays 1.
//   5. Reset mid-ADD: assert rst in T2 -> outputs and regs 0 immediately, Rx not written.
//      Release -> instr_ready=1 on the next clock.
//   6. Every cycle of a random 200-instr stream, W=16, NREG=8:
//      - tri_en one-hot or 0, done one pulse per instruction, regs match the reference model.

Source files
------------

// File: rtl/bus_cpu_seq.sv
// bus_cpu_seq: parametrised multicycle processor built around one shared internal bus.
//
// Every cycle at most one source drives the bus. The source is chosen by the registered
// one-hot tri_en vector. Instructions are fetched through a valid/ready handshake and then
// run through one to three execute states.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   instr_valid  instruction word on instr is valid
//   instr_ready  sequencer accepts an instruction (FETCH only, low while in reset)
//   instr        {op[2:0], rx, ry, imm[W-1:0]}
//   pc           program counter
//   bus          shared bus value, 0 when undriven
//   tri_en       bus source: [NREG-1:0]=Rn, [NREG]=imm, [NREG+1]=G
//   done         pulses high in the last execute cycle of each instruction
//   zero         zero flag from the most recent ALU op
//   dbg_sel      debug register select
//   dbg_data     Rn[dbg_sel], combinational
module bus_cpu_seq #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned PC_W = 8,
  localparam int unsigned RIDX = $clog2(NREG),
  localparam int unsigned IW   = 3 + 2 * RIDX + W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [IW-1:0]   instr,
  output logic [PC_W-1:0] pc,
  output logic [W-1:0]    bus,
  output logic [NREG+1:0] tri_en,
  output logic            done,
  output logic            zero,
  input  logic [RIDX-1:0] dbg_sel,
  output logic [W-1:0]    dbg_data
);

  typedef enum logic [1:0] {StFetch, StT1, StT2, StT3} state_e;

  typedef enum logic [2:0] {
    OpLoad = 3'b000,
    OpMv   = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpXor  = 3'b101,
    OpBz   = 3'b110,
    OpJmp  = 3'b111
  } op_e;

  localparam logic [NREG+1:0] TeOne = {{(NREG + 1){1'b0}}, 1'b1};
  localparam logic [NREG+1:0] SelImm = TeOne << NREG;
  localparam logic [NREG+1:0] SelG   = TeOne << (NREG + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    g_q, g_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG+1:0] tri_en_q, tri_en_d;
  logic            done_q, done_d;

  // Fields of the incoming word (used only to pick the first bus source).
  op_e             in_op;
  logic [RIDX-1:0] in_rx, in_ry;
  assign in_op = op_e'(instr[IW-1 -: 3]);
  assign in_rx = instr[W+2*RIDX-1 -: RIDX];
  assign in_ry = instr[W+RIDX-1 -: RIDX];

  // Fields of the latched instruction.
  op_e             ir_op;
  logic [RIDX-1:0] ir_rx, ir_ry;
  logic [W-1:0]    ir_imm;
  assign ir_op  = op_e'(ir_q[IW-1 -: 3]);
  assign ir_rx  = ir_q[W+2*RIDX-1 -: RIDX];
  assign ir_ry  = ir_q[W+RIDX-1 -: RIDX];
  assign ir_imm = ir_q[W-1:0];

  // Branch offset is sign-extended and jump target zero-padded when PC is wider than imm.
  logic [PC_W-1:0] br_off, jmp_tgt, pc_inc;
  if (PC_W > W) begin : g_pc_wide
    assign br_off  = {{(PC_W - W){ir_imm[W-1]}}, ir_imm};
    assign jmp_tgt = {{(PC_W - W){1'b0}}, ir_imm};
  end else begin : g_pc_narrow
    assign br_off  = ir_imm[PC_W-1:0];
    assign jmp_tgt = ir_imm[PC_W-1:0];
  end
  assign pc_inc = pc_q + {{(PC_W - 1){1'b0}}, 1'b1};

  // Bus is an OR of gated sources; tri_en_q is one-hot or zero, so at most one term is live.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (tri_en_q[i]) bus = bus | regs_q[i];
    end
    if (tri_en_q[NREG])   bus = bus | ir_imm;
    if (tri_en_q[NREG+1]) bus = bus | g_q;
  end

  logic [W-1:0] alu_res;
  always_comb begin
    case (ir_op)
      OpAdd:   alu_res = a_q + bus;
      OpSub:   alu_res = a_q - bus;
      OpAnd:   alu_res = a_q & bus;
      OpXor:   alu_res = a_q ^ bus;
      default: alu_res = '0;
    endcase
  end

  // Next state. tri_en and done are computed one cycle ahead so that they come
  // straight from flops in the cycle they apply to.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    a_d      = a_q;
    g_d      = g_q;
    zero_d   = zero_q;
    regs_d   = regs_q;
    tri_en_d = '0;
    done_d   = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StT1;
          unique case (in_op)
            OpLoad: begin
              tri_en_d = SelImm;
              done_d   = 1'b1;
            end
            OpMv: begin
              tri_en_d = TeOne << in_ry;
              done_d   = 1'b1;
            end
            OpBz, OpJmp: done_d = 1'b1;
            default:     tri_en_d = TeOne << in_rx;
          endcase
        end
      end
      StT1: begin
        unique case (ir_op)
          OpLoad, OpMv: begin
            regs_d[ir_rx] = bus;
            pc_d          = pc_inc;
            state_d       = StFetch;
          end
          OpBz: begin
            pc_d    = zero_q ? pc_q + br_off : pc_inc;
            state_d = StFetch;
          end
          OpJmp: begin
            pc_d    = jmp_tgt;
            state_d = StFetch;
          end
          default: begin
            a_d      = bus;
            tri_en_d = TeOne << ir_ry;
            state_d  = StT2;
          end
        endcase
      end
      StT2: begin
        g_d      = alu_res;
        tri_en_d = SelG;
        done_d   = 1'b1;
        state_d  = StT3;
      end
      StT3: begin
        regs_d[ir_rx] = bus;
        zero_d        = (g_q == '0);
        pc_d          = pc_inc;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      ir_q     <= '0;
      pc_q     <= '0;
      a_q      <= '0;
      g_q      <= '0;
      zero_q   <= 1'b0;
      regs_q   <= '{default: '0};
      tri_en_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      g_q      <= g_d;
      zero_q   <= zero_d;
      regs_q   <= regs_d;
      tri_en_q <= tri_en_d;
      done_q   <= done_d;
    end
  end

  assign instr_ready = (state_q == StFetch) && !rst;
  assign pc          = pc_q;
  assign tri_en      = tri_en_q;
  assign done        = done_q;
  assign zero        = zero_q;
  assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: tb/tb_bus_cpu_seq.sv
// Bench for bus_cpu_seq: a W=8/NREG=4 instance for directed steps and a W=16/NREG=8
// instance for a random instruction stream, both checked against a reference model.
module tb_bus_cpu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1, r1, d1, z1;
  logic [14:0] i1;
  logic [7:0]  pc1, bus1, dd1;
  logic [5:0]  te1;
  logic [1:0]  ds1;

  logic        v2, r2, d2, z2;
  logic [24:0] i2;
  logic [7:0]  pc2;
  logic [15:0] bus2, dd2;
  logic [9:0]  te2;
  logic [2:0]  ds2;

  bus_cpu_seq #(.W(8), .NREG(4), .PC_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .instr_valid(v1), .instr_ready(r1), .instr(i1), .pc(pc1),
    .bus(bus1), .tri_en(te1), .done(d1), .zero(z1), .dbg_sel(ds1), .dbg_data(dd1)
  );

  bus_cpu_seq #(.W(16), .NREG(8), .PC_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .instr_valid(v2), .instr_ready(r2), .instr(i2), .pc(pc2),
    .bus(bus2), .tri_en(te2), .done(d2), .zero(z2), .dbg_sel(ds2), .dbg_data(dd2)
  );

  typedef struct {
    int          lat;
    logic [7:0]  pc;
    logic        z;
    logic [15:0] rv;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] rm  [2][8];
  logic [7:0]  pcm [2];
  logic        zm  [2];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] o_bus(int d);
    return (d == 0) ? {8'h00, bus1} : bus2;
  endfunction
  function automatic logic [15:0] o_tri(int d);
    return (d == 0) ? {10'h000, te1} : {6'h00, te2};
  endfunction
  function automatic logic [7:0] o_pc(int d);
    return (d == 0) ? pc1 : pc2;
  endfunction
  function automatic logic o_ready(int d);
    return (d == 0) ? r1 : r2;
  endfunction
  function automatic logic o_done(int d);
    return (d == 0) ? d1 : d2;
  endfunction
  function automatic logic o_zero(int d);
    return (d == 0) ? z1 : z2;
  endfunction

  task automatic read_reg(input int d, input int idx, output logic [15:0] val);
    if (d == 0) ds1 = idx[1:0];
    else        ds2 = idx[2:0];
    #1;
    val = (d == 0) ? {8'h00, dd1} : dd2;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) rm[d][i] = '0;
      pcm[d] = '0;
      zm[d]  = 1'b0;
    end
  endtask

  // Issue one instruction, model it, then follow it cycle by cycle to its done pulse.
  task automatic issue(input int d, input logic [2:0] op, input int rx, input int ry,
                       input logic [15:0] imm_in);
    exp_t        e;
    logic [15:0] m, a, b, res, first, imm, val;
    int          n;
    logic        dn;
    m   = (d == 0) ? 16'h00FF : 16'hFFFF;
    imm = imm_in & m;
    @(negedge clk);
    chk("fetch_ready", o_ready(d), 1);
    chk("fetch_done", o_done(d), 0);
    chk("fetch_tri", o_tri(d), 0);
    if (d == 0) begin
      i1 = {op, rx[1:0], ry[1:0], imm[7:0]};
      v1 = 1'b1;
    end else begin
      i2 = {op, rx[2:0], ry[2:0], imm};
      v2 = 1'b1;
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v2 = 1'b0;

    a     = rm[d][rx];
    b     = rm[d][ry];
    res   = '0;
    first = '0;
    e.lat = 1;
    case (op)
      3'b000: begin first = imm; rm[d][rx] = imm; pcm[d] = pcm[d] + 8'd1; end
      3'b001: begin first = b;   rm[d][rx] = b;   pcm[d] = pcm[d] + 8'd1; end
      3'b110: pcm[d] = zm[d] ? pcm[d] + imm[7:0] : pcm[d] + 8'd1;
      3'b111: pcm[d] = imm[7:0];
      default: begin
        case (op)
          3'b010:  res = (a + b) & m;
          3'b011:  res = (a - b) & m;
          3'b100:  res = a & b;
          default: res = a ^ b;
        endcase
        first     = a;
        e.lat     = 3;
        rm[d][rx] = res;
        zm[d]     = (res == 16'h0);
        pcm[d]    = pcm[d] + 8'd1;
      end
    endcase
    e.pc = pcm[d];
    e.z  = zm[d];
    e.rv = rm[d][rx];
    sbq.push_back(e);

    n  = 0;
    dn = 1'b0;
    while (!dn && n < 8) begin
      @(negedge clk);
      n++;
      chk("tri_onehot0", $onehot0(o_tri(d)), 1);
      if (n == 1) chk("bus_t1", o_bus(d), first);
      if (e.lat == 3 && n == 2) chk("bus_t2", o_bus(d), b);
      if (e.lat == 3 && n == 3) chk("bus_t3", o_bus(d), res);
      dn = o_done(d);
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("latency", n, e.lat);
    chk("pc", o_pc(d), e.pc);
    chk("zero", o_zero(d), e.z);
    read_reg(d, rx, val);
    chk("reg_rx", val, e.rv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] val;
    logic [7:0]  pc_hold;
    v1 = 1'b0; v2 = 1'b0; i1 = '0; i2 = '0; ds1 = '0; ds2 = '0;
    reset_model();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready1", r1, 0);
    chk("rst_ready2", r2, 0);
    chk("rst_pc", pc1, 0);
    chk("rst_tri", te1, 0);
    chk("rst_bus", bus1, 0);
    chk("rst_done", d1, 0);
    chk("rst_zero", z1, 0);
    for (int i = 0; i < 4; i++) begin
      read_reg(0, i, val);
      chk("rst_reg", val, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", r1, 1);

    // LOAD, LOAD, ADD
    issue(0, 3'b000, 0, 0, 16'd5);
    issue(0, 3'b000, 1, 0, 16'd3);
    issue(0, 3'b010, 0, 1, 16'd0);
    read_reg(0, 0, val);
    chk("t1_r0", val, 8);
    chk("t1_zero", z1, 0);
    chk("t1_pc", pc1, 3);

    // SUB with borrow, then SUB Rx,Rx
    issue(0, 3'b000, 0, 0, 16'd3);
    issue(0, 3'b000, 1, 0, 16'd5);
    issue(0, 3'b011, 0, 1, 16'd0);
    read_reg(0, 0, val);
    chk("t2_r0", val, 8'hFE);
    chk("t2_zero0", z1, 0);
    issue(0, 3'b000, 2, 0, 16'd7);
    issue(0, 3'b011, 2, 2, 16'd0);
    read_reg(0, 2, val);
    chk("t2_r2", val, 0);
    chk("t2_zero1", z1, 1);

    // Branches
    issue(0, 3'b111, 0, 0, 16'd5);
    chk("t3_jmp5", pc1, 5);
    issue(0, 3'b110, 0, 0, 16'hFE);
    chk("t3_bz_taken", pc1, 3);
    issue(0, 3'b000, 0, 0, 16'd1);
    issue(0, 3'b000, 1, 0, 16'd1);
    issue(0, 3'b010, 0, 1, 16'd0);
    chk("t3_zero0", z1, 0);
    issue(0, 3'b111, 0, 0, 16'd5);
    issue(0, 3'b110, 0, 0, 16'hFE);
    chk("t3_bz_not", pc1, 6);
    issue(0, 3'b111, 0, 0, 16'h40);
    chk("t3_jmp40", pc1, 8'h40);
    issue(0, 3'b111, 0, 0, 16'hFF);
    issue(0, 3'b000, 3, 0, 16'h21);
    chk("t3_pc_wrap", pc1, 0);

    // Stall: nothing changes while instr_valid is low
    pc_hold = pc1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", r1, 1);
      chk("stall_tri", te1, 0);
      chk("stall_bus", bus1, 0);
      chk("stall_pc", pc1, pc_hold);
      read_reg(0, 3, val);
      chk("stall_r3", val, 8'h21);
    end

    // Flag preservation across LOAD/MV
    issue(0, 3'b011, 2, 2, 16'd0);
    issue(0, 3'b000, 3, 0, 16'd9);
    issue(0, 3'b001, 0, 3, 16'd0);
    issue(0, 3'b001, 1, 1, 16'd0);
    chk("t4_zero_kept", z1, 1);
    read_reg(0, 0, val);
    chk("t4_mv_r0", val, 9);

    // Reset in T2 of ADD R0,R1
    issue(0, 3'b000, 1, 0, 16'd4);
    issue(0, 3'b000, 0, 0, 16'd2);
    @(negedge clk);
    i1 = {3'b010, 2'd0, 2'd1, 8'h00};
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("t5_t1_tri", te1, 6'b000001);
    @(negedge clk);
    chk("t5_t2_tri", te1, 6'b000010);
    rst = 1'b1;
    #1;
    chk("t5_tri", te1, 0);
    chk("t5_bus", bus1, 0);
    chk("t5_done", d1, 0);
    chk("t5_pc", pc1, 0);
    chk("t5_ready", r1, 0);
    chk("t5_zero", z1, 0);
    read_reg(0, 0, val);
    chk("t5_r0", val, 0);
    read_reg(0, 1, val);
    chk("t5_r1", val, 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    chk("t5_ready_rel", r1, 1);
    chk("t5_tri_rel", te1, 0);
    chk("t5_r0_after", dd1, 0);
    issue(0, 3'b000, 3, 0, 16'h11);

    // Random stream on the wide instance
    for (int k = 0; k < 200; k++) begin
      issue(1, 3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
            16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(1, i, val);
      chk("rand_final_reg", val, rm[1][i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
